cordic_angle_prep: RTL and testbench
====================================

CORDIC_ANGLE_PREP -- requirements
Module: cordic_angle_prep

Interface
REQ-001 SHALL have parameter N, default 31; x/y data MSB index, data width N+1, signed Q12.20 two's complement.
REQ-002 SHALL have parameter M, default 31; angle MSB index, angle width M+1, Q12.20 degrees.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port x0  input  N+1 signed  input x coordinate.
REQ-006 SHALL have port y0  input  N+1 signed  input y coordinate.
REQ-007 SHALL have port inanglei  input  M+1 unsigned  rotation angle in degrees, 0 to just under 4096.
REQ-008 SHALL have port in_valid  input  1  upstream offers x0/y0/inanglei.
REQ-009 SHALL have port in_ready  output  1  block accepts a new input.
REQ-010 SHALL have port x_out  output  N+1 signed  folded x for the rotation core.
REQ-011 SHALL have port y_out  output  N+1 signed  folded y.
REQ-012 SHALL have port angle_out  output  M+1 signed  folded angle, range [-90, +90] degrees.
REQ-013 SHALL have port quadrant  output  2  quadrant of reduced angle: [0,90)=0, [90,180)=1, [180,270)=2, [270,360)=3.
REQ-014 SHALL have port out_valid  output  1  outputs valid for the rotation core.
REQ-015 SHALL have port out_ready  input  1  rotation core consumes output.

Function
REQ-016 SHALL implement FSM states IDLE, REDUCE, OUT.
REQ-017 SHALL drive in_ready = 1 only in IDLE; accept on the edge where in_valid && in_ready, registering x0, y0, inanglei, then go to REDUCE.
REQ-018 In REDUCE, each cycle the registered angle >= 360 (32'h168_00000), it SHALL subtract 360 and stay in REDUCE.
REQ-019 In REDUCE, the cycle the angle is < 360, it SHALL fold, load the output registers, and go to OUT.
REQ-020 Fold rules, a = reduced angle: a <= 90: angle_out = a, x/y unchanged; 90 < a <= 270: angle_out = a - 180, x/y negated; a > 270: angle_out = a - 360, x/y unchanged.
REQ-021 Negation of the most negative value 32'h8000_0000 SHALL saturate to 32'h7FFF_FFFF.
REQ-022 Latency: out_valid SHALL rise on the (k+2)th rising edge after the accept edge, where k = floor(inanglei/360), 0 <= k <= 11.
REQ-023 In OUT, out_valid = 1 and all outputs SHALL hold stable until out_valid && out_ready; on that edge the FSM returns to IDLE.
REQ-024 The block SHALL NOT accept an input in the same cycle as an output handshake; in_ready rises the cycle after.
REQ-025 x0 = y0 = 0 SHALL pass through without special handling, giving zero x_out/y_out.

Reset
REQ-026 While rst = 0, the FSM SHALL be in IDLE, in_ready = 1 (asserted combinationally from state), and out_valid = 0; x_out, y_out, angle_out, quadrant and internal registers SHALL be 0.
REQ-027 Assertion of rst mid-REDUCE or mid-OUT SHALL abort the transaction immediately; the pending result is discarded and never presented.

Structure
REQ-028 A shared package SHALL hold the Q12.20 angle constants (90, 180, 270, 360), the FSM state typedef and the quadrant encoding, reused by the rotation core.
REQ-029 The fold/saturating-negate logic SHALL be one combinational sub-module, cordic_quadrant_fold; no other sub-module.

Verification
REQ-030 x0=32'sh003_00000, y0=32'sh004_00000, inanglei=32'h14A_00000 (330) -> angle_out=32'hFE2_00000 (-30), x/y unchanged, quadrant=3, out_valid on 2nd edge after accept.
REQ-031 Same x/y, inanglei=32'h0D2_00000 (210) -> angle_out=32'h01E_00000, x_out=32'shFFD_00000, y_out=32'shFFC_00000, quadrant=2.
REQ-032 inanglei=32'h2D0_00000 (720) -> two REDUCE subtractions, angle_out=0, quadrant=0, out_valid on 4th edge after accept; inanglei=32'h05A_00000 (90) -> angle_out=+90, no negation, quadrant=1.
REQ-033 x0=32'h8000_0000, inanglei=32'h0B4_00000 (180) -> x_out=32'h7FFF_FFFF, angle_out=0.
REQ-034 Hold out_ready=0 for 5 cycles in OUT -> outputs stable, in_ready=0; out_ready=1 -> handshake, in_ready=1 next cycle.
REQ-035 rst pulsed low during REDUCE of 720 -> out_valid never rises for that input, all outputs 0, in_ready=1 after release.

Source files
------------

// File: rtl/cordic_angle_prep_pkg.sv
// Shared Q12.20 angle constants, FSM state type and quadrant encoding for the
// CORDIC angle-preparation stage and the rotation core that consumes it.
package cordic_angle_prep_pkg;

    localparam logic [31:0] ANG_90  = 32'h05A0_0000;
    localparam logic [31:0] ANG_180 = 32'h0B40_0000;
    localparam logic [31:0] ANG_270 = 32'h10E0_0000;
    localparam logic [31:0] ANG_360 = 32'h1680_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quadrant_t;

endpackage

// File: rtl/cordic_quadrant_fold.sv
// Folds a reduced angle in [0,360) into [-90,+90] degrees, negating x/y with
// saturation when the half-turn is removed; also reports the quadrant.
module cordic_quadrant_fold
    import cordic_angle_prep_pkg::*;
#(
    parameter int N = 31,
    parameter int M = 31
) (
    input  logic [M:0] angle,
    input  logic [N:0] x_in,
    input  logic [N:0] y_in,
    output logic [M:0] angle_fold,
    output logic [N:0] x_fold,
    output logic [N:0] y_fold,
    output logic [1:0] quadrant
);

    localparam int AW = M + 1;
    localparam logic [M:0] A90  = AW'(ANG_90);
    localparam logic [M:0] A180 = AW'(ANG_180);
    localparam logic [M:0] A270 = AW'(ANG_270);
    localparam logic [M:0] A360 = AW'(ANG_360);

    localparam logic [N:0] MOST_NEG = {1'b1, {N{1'b0}}};
    localparam logic [N:0] MOST_POS = ~MOST_NEG;
    localparam logic [N:0] ONE      = {{N{1'b0}}, 1'b1};

    // Plain two's-complement negation would wrap the most negative value onto itself.
    function automatic logic [N:0] sat_neg(input logic [N:0] v);
        return (v == MOST_NEG) ? MOST_POS : (~v) + ONE;
    endfunction

    always_comb begin
        angle_fold = angle;
        x_fold     = x_in;
        y_fold     = y_in;
        if (angle > A270) begin
            angle_fold = angle - A360;
        end else if (angle > A90) begin
            angle_fold = angle - A180;
            x_fold     = sat_neg(x_in);
            y_fold     = sat_neg(y_in);
        end

        quadrant = QUAD_0;
        if (angle >= A270)
            quadrant = QUAD_3;
        else if (angle >= A180)
            quadrant = QUAD_2;
        else if (angle >= A90)
            quadrant = QUAD_1;
    end

endmodule

// File: rtl/cordic_angle_prep.sv
// Angle range reduction and quadrant fold ahead of the CORDIC rotation core.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | in_ready high, waiting for an input handshake
// ST_REDUCE | subtract 360 per cycle until angle < 360, then fold + load
// ST_OUT    | first cycle arms out_valid, then hold outputs until consumed
module cordic_angle_prep
    import cordic_angle_prep_pkg::*;
#(
    parameter int N = 31,
    parameter int M = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [N:0] x0,
    input  logic [N:0] y0,
    input  logic [M:0] inanglei,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [N:0] x_out,
    output logic [N:0] y_out,
    output logic [M:0] angle_out,
    output logic [1:0] quadrant,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam int AW = M + 1;
    localparam logic [M:0] A360 = AW'(ANG_360);

    state_t     state;
    logic [N:0] x_reg;
    logic [N:0] y_reg;
    logic [M:0] ang_reg;
    logic [N:0] x_fold;
    logic [N:0] y_fold;
    logic [M:0] ang_fold;
    logic [1:0] quad_fold;

    cordic_quadrant_fold #(
        .N(N),
        .M(M)
    ) u_fold (
        .angle      (ang_reg),
        .x_in       (x_reg),
        .y_in       (y_reg),
        .angle_fold (ang_fold),
        .x_fold     (x_fold),
        .y_fold     (y_fold),
        .quadrant   (quad_fold)
    );

    assign in_ready = (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            ang_reg   <= '0;
            x_out     <= '0;
            y_out     <= '0;
            angle_out <= '0;
            quadrant  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_reg   <= x0;
                        y_reg   <= y0;
                        ang_reg <= inanglei;
                        state   <= ST_REDUCE;
                    end
                end
                ST_REDUCE: begin
                    if (ang_reg >= A360) begin
                        ang_reg <= ang_reg - A360;
                    end else begin
                        x_out     <= x_fold;
                        y_out     <= y_fold;
                        angle_out <= ang_fold;
                        quadrant  <= quad_fold;
                        state     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    // out_valid trails the state by one cycle so results appear k+2 edges after accept.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_angle_prep.sv
// Scoreboard bench for cordic_angle_prep: expected fold results are queued when
// an input is driven and popped when the block presents out_valid.
module tb_cordic_angle_prep;

    localparam logic [31:0] DEG90  = 32'd90  << 20;
    localparam logic [31:0] DEG180 = 32'd180 << 20;
    localparam logic [31:0] DEG270 = 32'd270 << 20;
    localparam logic [31:0] DEG360 = 32'd360 << 20;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] a;
        logic [1:0]  q;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] x0 = '0;
    logic [31:0] y0 = '0;
    logic [31:0] inanglei = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x_out;
    logic [31:0] y_out;
    logic [31:0] angle_out;
    logic [1:0]  quadrant;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    logic [31:0] vec [0:9][0:2] = '{
        '{32'h0030_0000, 32'h0040_0000, 32'h14A0_0000},
        '{32'h0030_0000, 32'h0040_0000, 32'h0D20_0000},
        '{32'h0030_0000, 32'h0040_0000, 32'h2D00_0000},
        '{32'h0030_0000, 32'h0040_0000, 32'h05A0_0000},
        '{32'h8000_0000, 32'h0040_0000, 32'h0B40_0000},
        '{32'h0000_0000, 32'h0000_0000, 32'h02D0_0000},
        '{32'h0010_0000, 32'hFFE0_0000, 32'h10E0_0000},
        '{32'h0050_0000, 32'h0060_0000, 32'h167F_FFFF},
        '{32'h0070_0000, 32'h0080_0000, 32'hFFFF_FFFF},
        '{32'h7FFF_FFFF, 32'h8000_0001, 32'h1680_0000}
    };

    cordic_angle_prep #(
        .N(31),
        .M(31)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .x0        (x0),
        .y0        (y0),
        .inanglei  (inanglei),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .angle_out (angle_out),
        .quadrant  (quadrant),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] neg_sat(input logic [31:0] v);
        return (v == 32'h8000_0000) ? 32'h7FFF_FFFF : 32'd0 - v;
    endfunction

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic [31:0] ang);
        exp_t        e;
        int unsigned k;
        logic [31:0] r;
        k = ang / DEG360;
        r = ang - k * DEG360;
        e.lat = int'(k) + 2;
        e.x = x;
        e.y = y;
        if (r < DEG90)       e.q = 2'd0;
        else if (r < DEG180) e.q = 2'd1;
        else if (r < DEG270) e.q = 2'd2;
        else                 e.q = 2'd3;
        if (r <= DEG90) begin
            e.a = r;
        end else if (r <= DEG270) begin
            e.a = r - DEG180;
            e.x = neg_sat(x);
            e.y = neg_sat(y);
        end else begin
            e.a = r - DEG360;
        end
        return e;
    endfunction

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] a, input bit track);
        if (track) sb.push_back(model(x, y, a));
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_in_ready: got %b expected 1", in_ready);
        end
        x0 = x;
        y0 = y;
        inanglei = a;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (out_valid === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        checks++;
        if ({x_out, y_out, angle_out, quadrant} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: x=%h y=%h a=%h q=%0d expected all 0", x_out, y_out, angle_out, quadrant);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fold();
        exp_t e;
        int   lat;
        for (int i = 0; i < 16; i++) begin
            if (i < 10) send(vec[i][0], vec[i][1], vec[i][2], 1'b1);
            else        send($urandom, $urandom, $urandom, 1'b1);
            wait_out(lat);
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL fold[%0d] latency: got %0d (valid=%b) expected %0d", i, lat, out_valid, e.lat);
            end
            checks++;
            if (angle_out !== e.a) begin
                errors++;
                $display("FAIL fold[%0d] angle: got %h expected %h", i, angle_out, e.a);
            end
            checks++;
            if (x_out !== e.x || y_out !== e.y) begin
                errors++;
                $display("FAIL fold[%0d] xy: got %h/%h expected %h/%h", i, x_out, y_out, e.x, e.y);
            end
            checks++;
            if (quadrant !== e.q) begin
                errors++;
                $display("FAIL fold[%0d] quadrant: got %0d expected %0d", i, quadrant, e.q);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL fold[%0d] release: in_ready=%b out_valid=%b expected 1/0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   lat;
        send(32'h0030_0000, 32'h0040_0000, 32'h0D20_0000, 1'b1);
        wait_out(lat);
        e = sb.pop_front();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || x_out !== e.x || y_out !== e.y
                || angle_out !== e.a || quadrant !== e.q) begin
                errors++;
                $display("FAIL hold[%0d]: v=%b r=%b x=%h y=%h a=%h q=%0d expected 1 0 %h %h %h %0d",
                         c, out_valid, in_ready, x_out, y_out, angle_out, quadrant, e.x, e.y, e.a, e.q);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(vec[i + 4][0], vec[i + 4][1], vec[i + 4][2], 1'b1);
            wait_out(lat);
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat || angle_out !== e.a || x_out !== e.x || quadrant !== e.q) begin
                errors++;
                $display("FAIL b2b[%0d]: lat=%0d a=%h x=%h q=%0d expected %0d %h %h %0d",
                         i, lat, angle_out, x_out, quadrant, e.lat, e.a, e.x, e.q);
            end
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b[%0d] in_ready_during_handshake: got %b expected 0", i, in_ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b[%0d] after_handshake: in_ready=%b out_valid=%b expected 1/0", i, in_ready, out_valid);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int   lat;
        bit   seen;
        out_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                send(32'h0030_0000, 32'h0040_0000, 32'h2D00_0000, 1'b0);
                @(posedge clk);
                #1;
            end else begin
                out_ready = 1'b0;
                send(32'h0030_0000, 32'h0040_0000, 32'h14A0_0000, 1'b0);
                wait_out(lat);
            end
            #2;
            rst = 1'b0;
            #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1
                || {x_out, y_out, angle_out, quadrant} !== '0) begin
                errors++;
                $display("FAIL abort[%0d] in_reset: v=%b r=%b x=%h y=%h a=%h q=%0d expected 0 1 and zeros",
                         pass, out_valid, in_ready, x_out, y_out, angle_out, quadrant);
            end
            @(negedge clk);
            rst = 1'b1;
            out_ready = 1'b1;
            seen = 1'b0;
            repeat (14) begin
                @(posedge clk);
                #1;
                if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
            end
            checks++;
            if (seen) begin
                errors++;
                $display("FAIL abort[%0d] discarded: result presented after reset, expected none", pass);
            end
        end
        send(32'h0030_0000, 32'h0040_0000, 32'h0D20_0000, 1'b1);
        wait_out(lat);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat || angle_out !== e.a || y_out !== e.y) begin
            errors++;
            $display("FAIL abort_recover: lat=%0d a=%h y=%h expected %0d %h %h", lat, angle_out, y_out, e.lat, e.a, e.y);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fold();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
